mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit with HI/LO result registers.
// Every operation takes a fixed 33 edges: 32 shift steps on magnitudes plus one sign-fixup edge.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_SIGN = 2'b10
    } state_t;

    state_t      state_q;
    logic        is_div_q;
    logic        neg_q;
    logic        rneg_q;
    logic [31:0] a_q;
    logic [31:0] y_q;
    logic [31:0] acc_q;
    logic [31:0] mq_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] acc_d;
    logic [31:0] mq_d;
    logic [32:0] add_s;
    logic [32:0] shifted_s;
    logic        ge_s;
    logic [63:0] prod_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        acc_signed_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        cond_neg32 = en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic en);
        cond_neg64 = en ? (~v + 64'd1) : v;
    endfunction

    // Operand magnitudes captured on the accepting edge; op[0] selects signed forms.
    always_comb begin
        acc_signed_s = op[0];
        a_mag_s      = cond_neg32(A, acc_signed_s & A[31]);
        b_mag_s      = cond_neg32(B, acc_signed_s & B[31]);
    end

    // One iteration of shift-add multiply or restoring shift-subtract divide.
    always_comb begin
        add_s     = 33'd0;
        shifted_s = {acc_q, mq_q[31]};
        ge_s      = (shifted_s >= {1'b0, y_q});
        acc_d     = acc_q;
        mq_d      = mq_q;
        if (is_div_q) begin
            if (ge_s) begin
                acc_d = shifted_s[31:0] - y_q;
                mq_d  = {mq_q[30:0], 1'b1};
            end else begin
                acc_d = shifted_s[31:0];
                mq_d  = {mq_q[30:0], 1'b0};
            end
        end else begin
            if (mq_q[0]) begin
                add_s = {1'b0, acc_q} + {1'b0, y_q};
            end else begin
                add_s = {1'b0, acc_q};
            end
            acc_d = add_s[32:1];
            mq_d  = {add_s[0], mq_q[31:1]};
        end
    end

    // Final HI/LO values: sign correction, with divide-by-zero overriding the iterative result.
    always_comb begin
        prod_s   = cond_neg64({acc_q, mq_q}, neg_q);
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
        if (is_div_q) begin
            if (y_q == 32'd0) begin
                res_hi_s = a_q;
                res_lo_s = 32'hFFFF_FFFF;
            end else begin
                res_hi_s = cond_neg32(acc_q, rneg_q);
                res_lo_s = cond_neg32(mq_q, neg_q);
            end
        end else begin
            res_hi_s = prod_s[63:32];
            res_lo_s = prod_s[31:0];
        end
    end

    // Control FSM, iteration datapath registers and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            a_q      <= 32'd0;
            y_q      <= 32'd0;
            acc_q    <= 32'd0;
            mq_q     <= 32'd0;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        is_div_q <= op[1];
                        neg_q    <= acc_signed_s & (A[31] ^ B[31]);
                        rneg_q   <= acc_signed_s & A[31];
                        a_q      <= A;
                        y_q      <= b_mag_s;
                        acc_q    <= 32'd0;
                        mq_q     <= a_mag_s;
                        cnt_q    <= 5'd0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CALC;
                    end else begin
                        // Moves to HI/LO are only honoured when no operation is being accepted.
                        if (mthi) begin
                            hi_q <= wdata;
                        end
                        if (mtlo) begin
                            lo_q <= wdata;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    if (cnt_q == 5'd31) begin
                        state_q <= ST_SIGN;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_SIGN: begin
                    hi_q    <= res_hi_s;
                    lo_q    <= res_lo_s;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
